// File: rtl/mips_exec_pkg.sv
// -----------------------------------------------------------------------------
// mips_exec_pkg
// Shared constants for the MIPS decode/execute slice: opcodes, R-type funct
// codes, 4-bit ALU control codes and the bit positions of the EX/MEM/WB
// control fields carried down the pipeline.
// -----------------------------------------------------------------------------
package mips_exec_pkg;

    // Opcodes (ins[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (ins[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    // ALU control codes
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_BAD = 4'b1111;

    // EX field {RegDst, ALUOp[1:0], ALUSrc}
    localparam int EX_REG_DST = 3;
    localparam int EX_ALU_OP  = 1;   // low bit of the 2-bit ALUOp
    localparam int EX_ALU_SRC = 0;
    // MEM field {Branch, MemRead, MemWrite}
    localparam int MEM_BRANCH = 2;
    localparam int MEM_READ   = 1;
    localparam int MEM_WRITE  = 0;
    // WB field {RegWrite, WBsel}
    localparam int WB_REG_WRITE = 1;
    localparam int WB_SEL       = 0;

    // Control bundle produced in ID and carried through ID/EX
    typedef struct packed {
        logic [3:0] ex;
        logic [2:0] mem;
        logic [1:0] wb;
    } ctrl_t;

    // ALU control decode from ALUOp and the funct field
    function automatic logic [3:0] alu_ctrl_f(input logic [1:0] alu_op,
                                              input logic [5:0] funct);
        logic [3:0] code;
        code = ALU_ADD;
        case (alu_op)
            2'b00: code = ALU_ADD;
            2'b01: code = ALU_SUB;
            2'b11: code = ALU_ADD;
            default: begin
                case (funct)
                    FN_ADD:  code = ALU_ADD;
                    FN_SUB:  code = ALU_SUB;
                    FN_AND:  code = ALU_AND;
                    FN_OR:   code = ALU_OR;
                    FN_SLT:  code = ALU_SLT;
                    FN_NOR:  code = ALU_NOR;
                    default: code = ALU_BAD;
                endcase
            end
        endcase
        return code;
    endfunction

endpackage

// File: rtl/mips_alu_core.sv
// -----------------------------------------------------------------------------
// mips_alu_core
// Purely combinational 32-bit ALU.
// Ports:
//   i_a, i_b   32-bit operands
//   i_ctrl     4-bit ALU control code (see mips_exec_pkg)
//   o_result   32-bit result, wraps mod 2^32; unknown codes give 0
//   o_zero     1 when o_result == 0
// -----------------------------------------------------------------------------
module mips_alu_core
    import mips_exec_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [3:0]  i_ctrl,
    output logic [31:0] o_result,
    output logic        o_zero
);

    always_comb begin
        o_result = 32'd0;
        case (i_ctrl)
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_ADD: o_result = i_a + i_b;
            ALU_SUB: o_result = i_a - i_b;
            ALU_SLT: o_result = ($signed(i_a) < $signed(i_b)) ? 32'd1 : 32'd0;
            ALU_NOR: o_result = ~(i_a | i_b);
            default: o_result = 32'd0;
        endcase
    end

    assign o_zero = (o_result == 32'd0);

endmodule

// File: rtl/mips_exec_ctrl.sv
// -----------------------------------------------------------------------------
// mips_exec_ctrl
// ID/EX slice of a 5-stage MIPS pipeline: main control decode, ID/EX and
// EX/MEM pipeline registers, ALU control decode and the ALU itself.
// Ports:
//   clk, rst (async, active-low)     clock and reset
//   flush                            load a bubble into ID/EX
//   ins, pc_plus4                    IF/ID instruction and PC+4
//   rd_data1, rd_data2               register file data for rs / rt
//   jump, jump_target                comb jump decode for IF
//   exm_mem, exm_wb                  EX/MEM control bundles
//   exm_alu_res, exm_zero            EX/MEM ALU result and zero flag
//   exm_wr_data, exm_reg_dst         EX/MEM store data, destination reg
//   exm_br_target                    EX/MEM branch target
//   pc_src                           take-branch select for IF
// -----------------------------------------------------------------------------
module mips_exec_ctrl
    import mips_exec_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] ins,
    input  logic [31:0] pc_plus4,
    input  logic [31:0] rd_data1,
    input  logic [31:0] rd_data2,
    output logic        jump,
    output logic [31:0] jump_target,
    output logic [2:0]  exm_mem,
    output logic [1:0]  exm_wb,
    output logic [31:0] exm_alu_res,
    output logic        exm_zero,
    output logic [31:0] exm_wr_data,
    output logic [4:0]  exm_reg_dst,
    output logic [31:0] exm_br_target,
    output logic        pc_src
);

    // ---------------- ID stage ----------------
    ctrl_t       w_ctrl;
    logic [31:0] w_imm;

    always_comb begin
        w_ctrl = '0;
        case (ins[31:26])
            OP_RTYPE: w_ctrl = '{ex: 4'b0101, mem: 3'b000, wb: 2'b11};
            OP_LW:    w_ctrl = '{ex: 4'b1000, mem: 3'b010, wb: 2'b10};
            OP_SW:    w_ctrl = '{ex: 4'b1000, mem: 3'b001, wb: 2'b00};
            OP_BEQ:   w_ctrl = '{ex: 4'b0011, mem: 3'b100, wb: 2'b00};
            OP_ADDI:  w_ctrl = '{ex: 4'b1000, mem: 3'b000, wb: 2'b11};
            default:  w_ctrl = '0;   // j and unknown opcodes carry no control
        endcase
    end

    assign jump        = (ins[31:26] == OP_J);
    assign jump_target = {4'b0000, ins[25:0], 2'b00};
    assign w_imm       = {{16{ins[15]}}, ins[15:0]};

    // ---------------- ID/EX register ----------------
    ctrl_t       r_idex_ctrl;
    logic [31:0] r_idex_pc4;
    logic [31:0] r_idex_rd1;
    logic [31:0] r_idex_rd2;
    logic [31:0] r_idex_imm;
    logic [4:0]  r_idex_rt;
    logic [4:0]  r_idex_rd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idex_ctrl <= '0;
            r_idex_pc4  <= 32'd0;
            r_idex_rd1  <= 32'd0;
            r_idex_rd2  <= 32'd0;
            r_idex_imm  <= 32'd0;
            r_idex_rt   <= 5'd0;
            r_idex_rd   <= 5'd0;
        end else begin
            // A flush only kills the control; the data fields are don't-care.
            r_idex_ctrl <= flush ? ctrl_t'('0) : w_ctrl;
            r_idex_pc4  <= pc_plus4;
            r_idex_rd1  <= rd_data1;
            r_idex_rd2  <= rd_data2;
            r_idex_imm  <= w_imm;
            r_idex_rt   <= ins[20:16];
            r_idex_rd   <= ins[15:11];
        end
    end

    // ---------------- EX stage ----------------
    logic [1:0]  w_alu_op;
    logic [3:0]  w_alu_ctrl;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_res;
    logic        w_alu_zero;
    logic [4:0]  w_reg_dst;
    logic [31:0] w_br_target;

    assign w_alu_op    = r_idex_ctrl.ex[EX_ALU_OP+1:EX_ALU_OP];
    assign w_alu_ctrl  = alu_ctrl_f(w_alu_op, r_idex_imm[5:0]);
    // ALUSrc=1 takes the register operand, 0 takes the immediate.
    assign w_alu_b     = r_idex_ctrl.ex[EX_ALU_SRC] ? r_idex_rd2 : r_idex_imm;
    // RegDst=1 selects rt, 0 selects rd.
    assign w_reg_dst   = r_idex_ctrl.ex[EX_REG_DST] ? r_idex_rt : r_idex_rd;
    assign w_br_target = r_idex_pc4 + {r_idex_imm[29:0], 2'b00};

    mips_alu_core u_alu (
        .i_a      (r_idex_rd1),
        .i_b      (w_alu_b),
        .i_ctrl   (w_alu_ctrl),
        .o_result (w_alu_res),
        .o_zero   (w_alu_zero)
    );

    // ---------------- EX/MEM register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exm_mem       <= 3'd0;
            exm_wb        <= 2'd0;
            exm_alu_res   <= 32'd0;
            exm_zero      <= 1'b0;
            exm_wr_data   <= 32'd0;
            exm_reg_dst   <= 5'd0;
            exm_br_target <= 32'd0;
        end else begin
            exm_mem       <= r_idex_ctrl.mem;
            exm_wb        <= r_idex_ctrl.wb;
            exm_alu_res   <= w_alu_res;
            exm_zero      <= w_alu_zero;
            exm_wr_data   <= r_idex_rd2;
            exm_reg_dst   <= w_reg_dst;
            exm_br_target <= w_br_target;
        end
    end

    assign pc_src = exm_mem[MEM_BRANCH] & exm_zero;

endmodule

// File: tb/tb_mips_exec_ctrl.sv
module tb_mips_exec_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] ins = 32'hFC00_0000;
    logic [31:0] pc_plus4 = 32'd0;
    logic [31:0] rd_data1 = 32'd0;
    logic [31:0] rd_data2 = 32'd0;
    logic        jump;
    logic [31:0] jump_target;
    logic [2:0]  exm_mem;
    logic [1:0]  exm_wb;
    logic [31:0] exm_alu_res;
    logic        exm_zero;
    logic [31:0] exm_wr_data;
    logic [4:0]  exm_reg_dst;
    logic [31:0] exm_br_target;
    logic        pc_src;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] NOP_INS = 32'hFC00_0000;   // opcode 111111: no control

    mips_exec_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .ins           (ins),
        .pc_plus4      (pc_plus4),
        .rd_data1      (rd_data1),
        .rd_data2      (rd_data2),
        .jump          (jump),
        .jump_target   (jump_target),
        .exm_mem       (exm_mem),
        .exm_wb        (exm_wb),
        .exm_alu_res   (exm_alu_res),
        .exm_zero      (exm_zero),
        .exm_wr_data   (exm_wr_data),
        .exm_reg_dst   (exm_reg_dst),
        .exm_br_target (exm_br_target),
        .pc_src        (pc_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction for one edge, then a NOP for the next edge,
    // so the instruction's results sit on exm_* when this returns.
    task automatic issue(input string name, input logic [31:0] i_ins,
                         input logic [31:0] pc4, input logic [31:0] d1,
                         input logic [31:0] d2, input logic fl);
        ins = i_ins; pc_plus4 = pc4; rd_data1 = d1; rd_data2 = d2; flush = fl;
        step();
        ins = NOP_INS; flush = 1'b0;
        step();
        $display("txn %-10s ins=%h a=%h b=%h -> res=%h zero=%0d mem=%b wb=%b dst=%0d brt=%h",
                 name, i_ins, d1, d2, exm_alu_res, exm_zero, exm_mem, exm_wb,
                 exm_reg_dst, exm_br_target);
    endtask

    initial begin
        // ---- reset state ----
        #1;
        chk("rst_mem", exm_mem, 3'b000);
        chk("rst_wb", exm_wb, 2'b00);
        chk("rst_res", exm_alu_res, 32'd0);
        chk("rst_pcsrc", pc_src, 1'b0);
        #2 rst = 1'b1;

        // ---- R add: 5 + 7, rd=3 ----
        issue("add", 32'h0022_1820, 32'd0, 32'd5, 32'd7, 1'b0);
        chk("add_res", exm_alu_res, 32'd12);
        chk("add_zero", exm_zero, 1'b0);
        chk("add_dst", exm_reg_dst, 5'd3);
        chk("add_wb", exm_wb, 2'b11);
        chk("add_mem", exm_mem, 3'b000);
        chk("add_wrdata", exm_wr_data, 32'd7);

        // ---- beq taken: 9 == 9, imm 4, pc+4 = 100 ----
        issue("beq_eq", 32'h1022_0004, 32'd100, 32'd9, 32'd9, 1'b0);
        chk("beq_target", exm_br_target, 32'd116);
        chk("beq_zero", exm_zero, 1'b1);
        chk("beq_mem", exm_mem, 3'b100);
        chk("beq_pcsrc", pc_src, 1'b1);

        // ---- beq not taken ----
        issue("beq_ne", 32'h1022_0004, 32'd100, 32'd9, 32'd8, 1'b0);
        chk("beqne_pcsrc", pc_src, 1'b0);
        chk("beqne_zero", exm_zero, 1'b0);

        // ---- lw: 0x1000 + (-4), rt=5 ----
        issue("lw", 32'h8C25_FFFC, 32'd0, 32'h0000_1000, 32'h1234_5678, 1'b0);
        chk("lw_res", exm_alu_res, 32'h0000_0FFC);
        chk("lw_mem", exm_mem, 3'b010);
        chk("lw_wb", exm_wb, 2'b10);
        chk("lw_dst", exm_reg_dst, 5'd5);

        // ---- sw: 0x20 + 8, store data from rt ----
        issue("sw", 32'hAC25_0008, 32'd0, 32'h0000_0020, 32'hCAFE_BABE, 1'b0);
        chk("sw_res", exm_alu_res, 32'h0000_0028);
        chk("sw_mem", exm_mem, 3'b001);
        chk("sw_wb", exm_wb, 2'b00);
        chk("sw_wrdata", exm_wr_data, 32'hCAFE_BABE);

        // ---- addi: 0 + sext(0xFFFF) ----
        issue("addi", 32'h2025_FFFF, 32'd0, 32'd0, 32'd3, 1'b0);
        chk("addi_res", exm_alu_res, 32'hFFFF_FFFF);
        chk("addi_wb", exm_wb, 2'b11);
        chk("addi_dst", exm_reg_dst, 5'd5);

        // ---- slt signed: -1 < 1 ----
        issue("slt", 32'h0022_202A, 32'd0, 32'hFFFF_FFFF, 32'd1, 1'b0);
        chk("slt_res", exm_alu_res, 32'd1);
        chk("slt_dst", exm_reg_dst, 5'd4);
        issue("slt_swap", 32'h0022_202A, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
        chk("sltsw_res", exm_alu_res, 32'd0);
        chk("sltsw_zero", exm_zero, 1'b1);

        // ---- logic ops and unknown funct ----
        issue("and", 32'h0022_1824, 32'd0, 32'h0000_F0F0, 32'h0000_FF00, 1'b0);
        chk("and_res", exm_alu_res, 32'h0000_F000);
        issue("or", 32'h0022_1825, 32'd0, 32'h0000_F0F0, 32'h0000_FF00, 1'b0);
        chk("or_res", exm_alu_res, 32'h0000_FFF0);
        issue("nor", 32'h0022_1827, 32'd0, 32'h0000_F0F0, 32'h0000_FF00, 1'b0);
        chk("nor_res", exm_alu_res, 32'hFFFF_000F);
        issue("sub", 32'h0022_1822, 32'd0, 32'd3, 32'd5, 1'b0);
        chk("sub_res", exm_alu_res, 32'hFFFF_FFFE);
        issue("badfn", 32'h0022_1821, 32'd0, 32'd3, 32'd5, 1'b0);
        chk("badfn_res", exm_alu_res, 32'd0);
        chk("badfn_zero", exm_zero, 1'b1);

        // ---- j: combinational jump, no control downstream ----
        ins = 32'h0800_0040;
        #1;
        chk("j_jump", jump, 1'b1);
        chk("j_target", jump_target, 32'h0000_0100);
        step();
        chk("j_idex_ctrl", dut.r_idex_ctrl, 9'd0);
        ins = NOP_INS;
        #1;
        chk("nop_jump", jump, 1'b0);
        step();
        chk("j_mem", exm_mem, 3'b000);
        chk("j_wb", exm_wb, 2'b00);
        $display("txn %-10s jump target checked, downstream control=%b%b", "j", exm_mem, exm_wb);

        // ---- flush beats a valid R-type ----
        issue("flush", 32'h0022_1820, 32'd0, 32'd5, 32'd7, 1'b1);
        chk("flush_wb", exm_wb, 2'b00);
        chk("flush_mem", exm_mem, 3'b000);

        // ---- reset mid-stream ----
        issue("pre_rst", 32'h1022_0004, 32'd100, 32'd9, 32'd9, 1'b0);
        chk("prerst_pcsrc", pc_src, 1'b1);
        ins = 32'h0022_1820; rd_data1 = 32'd5; rd_data2 = 32'd7;
        step();                       // add now in flight in ID/EX
        #2 rst = 1'b0;
        ins = 32'h0800_0040;
        #1;
        chk("rst_mid_mem", exm_mem, 3'b000);
        chk("rst_mid_wb", exm_wb, 2'b00);
        chk("rst_mid_res", exm_alu_res, 32'd0);
        chk("rst_mid_zero", exm_zero, 1'b0);
        chk("rst_mid_tgt", exm_br_target, 32'd0);
        chk("rst_mid_pcsrc", pc_src, 1'b0);
        chk("rst_mid_jump", jump, 1'b1);
        $display("txn %-10s exm cleared asynchronously", "reset");
        #2 rst = 1'b1;
        ins = NOP_INS;
        step();                       // in-flight add was discarded
        chk("post_rst_wb", exm_wb, 2'b00);
        chk("post_rst_res", exm_alu_res, 32'd0);

        // ---- refill after reset: 2-edge latency ----
        ins = 32'h0022_1820; rd_data1 = 32'd20; rd_data2 = 32'd22;
        step();
        chk("refill_e1_wb", exm_wb, 2'b00);
        ins = NOP_INS;
        step();
        chk("refill_res", exm_alu_res, 32'd42);
        chk("refill_wb", exm_wb, 2'b11);
        $display("txn %-10s res=%h wb=%b", "refill", exm_alu_res, exm_wb);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
